mem_port_responder: RTL and testbench

//  Memory-side responder for the pipelined datapath's split instruction/data ports.

---
 rtl/mem_port_responder_if.sv | 33 +++
 rtl/mem_port_responder.sv | 123 ++++++++++++
 tb/tb_mem_port_responder.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_responder_if.sv
// rtl/mem_port_responder_if.sv - datapath request/response and pmem bus bundle for mem_port_responder
interface mem_port_responder_if;
  logic [31:0] instr_mem_addr;
  logic [31:0] instr_mem_rdata;
  logic [31:0] data_mem_addr;
  logic        data_mem_read;
  logic        data_mem_write;
  logic [3:0]  data_mem_byte_en;
  logic [31:0] data_mem_wdata;
  logic [31:0] data_mem_rdata;
  logic        cache_hit;
  logic [31:0] pmem_addr;
  logic        pmem_read;
  logic        pmem_write;
  logic [3:0]  pmem_byte_en;
  logic [31:0] pmem_wdata;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  modport slave (
    input  instr_mem_addr, data_mem_addr, data_mem_read, data_mem_write,
           data_mem_byte_en, data_mem_wdata, pmem_rdata, pmem_resp,
    output instr_mem_rdata, data_mem_rdata, cache_hit, pmem_addr, pmem_read,
           pmem_write, pmem_byte_en, pmem_wdata
  );

  modport master (
    output instr_mem_addr, data_mem_addr, data_mem_read, data_mem_write,
           data_mem_byte_en, data_mem_wdata, pmem_rdata, pmem_resp,
    input  instr_mem_rdata, data_mem_rdata, cache_hit, pmem_addr, pmem_read,
           pmem_write, pmem_byte_en, pmem_wdata
  );
endinterface

// File: rtl/mem_port_responder.sv
// rtl/mem_port_responder.sv - serves one fetch plus optional load/store per pipeline step over a shared pmem port
module mem_port_responder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_responder_if.slave bus,
  output logic                err
);
  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, IFETCH, DACC, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] iaddr_q, daddr_q, wdata_q;
  logic        rd_q, wr_q;
  logic [3:0]  be_q;
  logic        ib_valid;
  logic [29:0] ib_word;
  logic [7:0]  wait_cnt, wait_inc;
  logic        ib_hit, in_access;

  assign ib_hit    = ib_valid && (ib_word == bus.instr_mem_addr[31:2]);
  assign in_access = (state == IFETCH) || (state == DACC);
  assign wait_inc  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // IDLE decides on the live inputs; later states use the copies latched in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!ib_hit)                                      state_next = IFETCH;
        else if (bus.data_mem_read || bus.data_mem_write) state_next = DACC;
        else                                              state_next = DONE;
      end
      IFETCH: if (bus.pmem_resp) state_next = (rd_q || wr_q) ? DACC : DONE;
      DACC:   if (bus.pmem_resp) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_addr    = 32'h0;
    bus.pmem_byte_en = 4'h0;
    bus.pmem_wdata   = 32'h0;
    bus.cache_hit    = 1'b0;
    case (state)
      IFETCH: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_addr    = iaddr_q & WORD_MASK;
        bus.pmem_byte_en = 4'hF;
      end
      DACC: begin
        bus.pmem_addr = daddr_q & WORD_MASK;
        // A simultaneous read and write request resolves to the write.
        if (wr_q) begin
          bus.pmem_write   = 1'b1;
          bus.pmem_byte_en = be_q;
          bus.pmem_wdata   = wdata_q;
        end else begin
          bus.pmem_read    = 1'b1;
          bus.pmem_byte_en = 4'hF;
        end
      end
      DONE:    bus.cache_hit = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iaddr_q             <= 32'h0;
      daddr_q             <= 32'h0;
      wdata_q             <= 32'h0;
      rd_q                <= 1'b0;
      wr_q                <= 1'b0;
      be_q                <= 4'h0;
      ib_valid            <= 1'b0;
      ib_word             <= 30'h0;
      wait_cnt            <= 8'h0;
      err                 <= 1'b0;
      bus.instr_mem_rdata <= 32'h0;
      bus.data_mem_rdata  <= 32'h0;
    end else begin
      // Counter is zero whenever an access begins, since it clears outside accesses and on each response.
      if (in_access && !bus.pmem_resp) begin
        wait_cnt <= wait_inc;
        if (wait_inc == TIMEOUT_CNT) err <= 1'b1;
      end else begin
        wait_cnt <= 8'h0;
      end
      case (state)
        IDLE: begin
          iaddr_q <= bus.instr_mem_addr;
          daddr_q <= bus.data_mem_addr;
          wdata_q <= bus.data_mem_wdata;
          rd_q    <= bus.data_mem_read;
          wr_q    <= bus.data_mem_write;
          be_q    <= bus.data_mem_byte_en;
        end
        IFETCH: if (bus.pmem_resp) begin
          bus.instr_mem_rdata <= bus.pmem_rdata;
          ib_valid            <= 1'b1;
          ib_word             <= iaddr_q[31:2];
        end
        DACC: if (bus.pmem_resp) begin
          if (!wr_q)                                       bus.data_mem_rdata <= bus.pmem_rdata;
          else if (ib_valid && ib_word == daddr_q[31:2])   ib_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_responder.sv
// tb/tb_mem_port_responder.sv - randomized self-checking bench with a step-level reference model and pmem responder
module tb_mem_port_responder;
  logic clk = 1'b0;
  logic rst_n;
  logic err;

  mem_port_responder_if bus ();

  mem_port_responder #(.TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // pmem environment: backing store, per-access wait plan, access log
  logic [31:0] mem [logic [29:0]];
  int          wait_plan[$];
  bit          spurious = 0;
  bit          both_seen = 0;
  logic [68:0] got_acc[$];
  int          got_wait_sum;
  bit          active = 0;
  int          k, w;

  function automatic logic [31:0] mem_word(logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
  endfunction

  initial begin
    logic [31:0] cur;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (!rst_n) begin
        active = 0;
      end else begin
        if (bus.pmem_read && bus.pmem_write) both_seen = 1;
        if ((bus.pmem_read || bus.pmem_write) && !active) begin
          active = 1;
          k = 0;
          w = (wait_plan.size() > 0) ? wait_plan.pop_front() : int'($urandom_range(0, 4));
          got_acc.push_back({bus.pmem_addr, bus.pmem_write, bus.pmem_byte_en,
                             bus.pmem_write ? bus.pmem_wdata : 32'h0});
          got_wait_sum += w + 1;
        end
        if (active) begin
          if (k == w) begin
            bus.pmem_resp = 1'b1;
            if (bus.pmem_write) begin
              cur = mem_word(bus.pmem_addr[31:2]);
              for (int b = 0; b < 4; b++)
                if (bus.pmem_byte_en[b]) cur[8*b +: 8] = bus.pmem_wdata[8*b +: 8];
              mem[bus.pmem_addr[31:2]] = cur;
              bus.pmem_rdata = $urandom;
            end else begin
              bus.pmem_rdata = mem_word(bus.pmem_addr[31:2]);
            end
            active = 0;
          end else begin
            k++;
          end
        end else if (spurious) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = $urandom;
        end
      end
    end
  end

  // Step-level reference model
  bit          ref_ib_valid;
  logic [29:0] ref_ib_word;
  logic [31:0] ref_instr, ref_data;
  logic [68:0] exp_acc[$];
  bit          idle_now;
  int          lat, exp_lat;

  task automatic model_reset();
    ref_ib_valid = 0;
    ref_ib_word  = '0;
    ref_instr    = 32'h0;
    ref_data     = 32'h0;
  endtask

  task automatic drive_idle_inputs();
    bus.instr_mem_addr   = 32'h0;
    bus.data_mem_addr    = 32'h0;
    bus.data_mem_read    = 1'b0;
    bus.data_mem_write   = 1'b0;
    bus.data_mem_byte_en = 4'h0;
    bus.data_mem_wdata   = 32'h0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle_inputs();
    wait_plan.delete();
    spurious = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    idle_now = 1;
  endtask

  task automatic run_step(input logic [31:0] ia, input bit rd, input bit wr,
                          input logic [31:0] da, input logic [3:0] be, input logic [31:0] wd);
    exp_acc.delete();
    got_acc.delete();
    got_wait_sum = 0;
    if (!(ref_ib_valid && ref_ib_word == ia[31:2])) begin
      exp_acc.push_back({ia & 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0});
      ref_instr    = mem_word(ia[31:2]);
      ref_ib_valid = 1;
      ref_ib_word  = ia[31:2];
    end
    if (wr) begin
      exp_acc.push_back({da & 32'hFFFF_FFFC, 1'b1, be, wd});
      if (ref_ib_valid && ref_ib_word == da[31:2]) ref_ib_valid = 0;
    end else if (rd) begin
      exp_acc.push_back({da & 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0});
      ref_data = mem_word(da[31:2]);
    end
    bus.instr_mem_addr   = ia;
    bus.data_mem_addr    = da;
    bus.data_mem_read    = rd;
    bus.data_mem_write   = wr;
    bus.data_mem_byte_en = be;
    bus.data_mem_wdata   = wd;
    lat = idle_now ? 1 : 0;
    idle_now = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      lat++;
      if (bus.cache_hit) break;
    end
    if (!bus.cache_hit) lat = -1;
    exp_lat = 2 + got_wait_sum;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (bus.cache_hit !== 1'b0)       begin errors++; $display("FAIL reset_cache_hit: got %0b want 0", bus.cache_hit); end
    checks++; if (bus.pmem_read !== 1'b0)       begin errors++; $display("FAIL reset_pmem_read: got %0b want 0", bus.pmem_read); end
    checks++; if (bus.pmem_write !== 1'b0)      begin errors++; $display("FAIL reset_pmem_write: got %0b want 0", bus.pmem_write); end
    checks++; if (bus.instr_mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_instr_rdata: got %0h want 0", bus.instr_mem_rdata); end
    checks++; if (bus.data_mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_data_rdata: got %0h want 0", bus.data_mem_rdata); end
    checks++; if (err !== 1'b0)                 begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
  endtask

  task automatic test_fetch_miss();
    wait_plan.push_back(3);
    run_step(32'h60, 0, 0, 32'h0, 4'h0, 32'h0);
    checks++; if (lat !== 6) begin errors++; $display("FAIL miss_latency: got %0d want 6", lat); end
    checks++; if (got_acc.size() != 1 || got_acc[0] !== {32'h60, 1'b0, 4'hF, 32'h0})
      begin errors++; $display("FAIL miss_access: got %0d accesses first %0h want 1 read of 60", got_acc.size(), got_acc.size() ? got_acc[0] : 69'h0); end
    checks++; if (bus.instr_mem_rdata !== ref_instr) begin errors++; $display("FAIL miss_instr_rdata: got %0h want %0h", bus.instr_mem_rdata, ref_instr); end
  endtask

  task automatic test_ibuf_hit();
    logic [31:0] prev_i, prev_d;
    prev_i = bus.instr_mem_rdata;
    prev_d = bus.data_mem_rdata;
    run_step(32'h60, 0, 0, 32'h0, 4'h0, 32'h0);
    checks++; if (lat !== 2) begin errors++; $display("FAIL hit_latency: got %0d want 2", lat); end
    checks++; if (got_acc.size() != 0) begin errors++; $display("FAIL hit_no_pmem: got %0d accesses want 0", got_acc.size()); end
    checks++; if (bus.instr_mem_rdata !== prev_i || prev_i !== ref_instr) begin errors++; $display("FAIL hit_instr_rdata: got %0h want %0h", bus.instr_mem_rdata, ref_instr); end
    checks++; if (bus.data_mem_rdata !== prev_d) begin errors++; $display("FAIL hit_data_rdata: got %0h want %0h", bus.data_mem_rdata, prev_d); end
  endtask

  task automatic test_store_invalidate();
    run_step(32'h60, 0, 1, 32'h62, 4'b0100, 32'hA7A7_A7A7);
    checks++; if (got_acc.size() != 1 || got_acc[0] !== {32'h60, 1'b1, 4'h4, 32'hA7A7_A7A7})
      begin errors++; $display("FAIL store_access: got %0d accesses first %0h want write 60 be 4", got_acc.size(), got_acc.size() ? got_acc[0] : 69'h0); end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL store_latency: got %0d want %0d", lat, exp_lat); end
    run_step(32'h60, 0, 0, 32'h0, 4'h0, 32'h0);
    checks++; if (got_acc.size() != 1 || got_acc[0] !== {32'h60, 1'b0, 4'hF, 32'h0})
      begin errors++; $display("FAIL refetch_miss: got %0d accesses want 1 read of 60", got_acc.size()); end
    checks++; if (bus.instr_mem_rdata !== ref_instr) begin errors++; $display("FAIL refetch_instr: got %0h want %0h", bus.instr_mem_rdata, ref_instr); end
  endtask

  task automatic test_load_after_miss();
    wait_plan.push_back(1);
    wait_plan.push_back(2);
    run_step(32'h80, 1, 0, 32'h1003, 4'h0, 32'h0);
    checks++; if (got_acc.size() != 2 || got_acc[1] !== {32'h1000, 1'b0, 4'hF, 32'h0})
      begin errors++; $display("FAIL load_access: got %0d accesses want fetch then read of 1000", got_acc.size()); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL load_latency: got %0d want 7", lat); end
    checks++; if (bus.data_mem_rdata !== ref_data) begin errors++; $display("FAIL load_data: got %0h want %0h", bus.data_mem_rdata, ref_data); end
    checks++; if (bus.instr_mem_rdata !== ref_instr) begin errors++; $display("FAIL load_instr: got %0h want %0h", bus.instr_mem_rdata, ref_instr); end
  endtask

  task automatic test_spurious_resp();
    spurious = 1;
    run_step(32'h80, 0, 0, 32'h0, 4'h0, 32'h0);
    spurious = 0;
    checks++; if (lat !== 2) begin errors++; $display("FAIL spurious_latency: got %0d want 2", lat); end
    checks++; if (bus.instr_mem_rdata !== ref_instr) begin errors++; $display("FAIL spurious_instr: got %0h want %0h", bus.instr_mem_rdata, ref_instr); end
    checks++; if (bus.data_mem_rdata !== ref_data) begin errors++; $display("FAIL spurious_data: got %0h want %0h", bus.data_mem_rdata, ref_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ia, da;
    bit rd, wr;
    for (int i = 0; i < 40; i++) begin
      ia = 32'h60 + 32'($urandom_range(0, 3)) * 4;
      da = ($urandom_range(0, 1) ? 32'h60 : 32'h1000) + 32'($urandom_range(0, 15));
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 2) == 0);
      run_step(ia, rd, wr, da, 4'($urandom), $urandom);
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, exp_lat); end
      checks++;
      if (got_acc.size() != exp_acc.size()) begin
        errors++; $display("FAIL rand_access_count[%0d]: got %0d want %0d", i, got_acc.size(), exp_acc.size());
      end else begin
        foreach (exp_acc[j]) if (got_acc[j] !== exp_acc[j]) begin
          errors++; $display("FAIL rand_access[%0d.%0d]: got %0h want %0h", i, j, got_acc[j], exp_acc[j]);
        end
      end
      checks++; if (bus.instr_mem_rdata !== ref_instr) begin errors++; $display("FAIL rand_instr[%0d]: got %0h want %0h", i, bus.instr_mem_rdata, ref_instr); end
      checks++; if (bus.data_mem_rdata !== ref_data) begin errors++; $display("FAIL rand_data[%0d]: got %0h want %0h", i, bus.data_mem_rdata, ref_data); end
    end
    checks++; if (both_seen) begin errors++; $display("FAIL read_write_exclusive: got both high want never"); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err: got %0b want 0", err); end
  endtask

  task automatic test_timeout();
    bit hit_seen = 0;
    bit rd_drop = 0;
    reset_dut();
    wait_plan.push_back(100000);
    bus.instr_mem_addr = 32'h40;
    idle_now = 0;
    for (int n = 2; n <= 300; n++) begin
      @(negedge clk);
      if (bus.cache_hit) hit_seen = 1;
      if (!bus.pmem_read) rd_drop = 1;
      if (n == 256) begin checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_early: got err %0b want 0", err); end end
      if (n == 257) begin checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got err %0b want 1", err); end end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %0b want 1", err); end
    checks++; if (rd_drop) begin errors++; $display("FAIL timeout_read_held: got dropped want held"); end
    checks++; if (hit_seen) begin errors++; $display("FAIL timeout_cache_hit: got pulse want none"); end
  endtask

  task automatic test_reset_mid_access();
    bit found = 0;
    reset_dut();
    run_step(32'h200, 0, 0, 32'h0, 4'h0, 32'h0);
    wait_plan.push_back(100000);
    bus.instr_mem_addr   = 32'h200;
    bus.data_mem_write   = 1'b1;
    bus.data_mem_addr    = 32'h300;
    bus.data_mem_byte_en = 4'hF;
    bus.data_mem_wdata   = $urandom;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (bus.pmem_write) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_write_seen: got no pmem_write want one"); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b0)
      begin errors++; $display("FAIL rstmid_drop: got rd %0b wr %0b want 0 0", bus.pmem_read, bus.pmem_write); end
    drive_idle_inputs();
    model_reset();
    wait_plan.delete();
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    idle_now = 1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %0b want 0", err); end
    run_step(32'h200, 0, 0, 32'h0, 4'h0, 32'h0);
    checks++; if (got_acc.size() != 1 || got_acc[0] !== {32'h200, 1'b0, 4'hF, 32'h0})
      begin errors++; $display("FAIL rstmid_ibuf_invalid: got %0d accesses want 1 read of 200", got_acc.size()); end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rstmid_latency: got %0d want %0d", lat, exp_lat); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle_inputs();
    test_reset();
    test_fetch_miss();
    test_ibuf_hit();
    test_store_invalidate();
    test_load_after_miss();
    test_spurious_resp();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
